spi_master_slave: RTL and testbench

Self-contained SPI link containing one SPI master and one SPI slave, both clocked by the system clock and wired together internally.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, single full-duplex DATA_W-bit exchange per start.
- The master shifts m_data_in out while receiving the slave's s_data_in. The slave does the reverse.
- Bus pins are brought out as outputs for observation and loopback verification of the SPI protocol layer.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_slave_core.sv | 107 ++++++++++
 rtl/spi_master_slave.sv | 180 ++++++++++++++++++
 tb/tb_spi_master_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the spi_master_slave link.
//   master_state_t : master FSM state encoding
//   DEF_DATA_W     : default bits per transfer
//   DEF_CLK_DIV    : default clk cycles per sclk half-period
//   cnt_w()        : width of a counter that must hold 0..n
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } master_state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 2;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave running in the system clock domain. sclk and ss are
// oversampled; edges are found by comparing each input with its value
// from the previous clk cycle.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   sclk, ss, mosi    : bus inputs from the master
//   miso              : slave serial output (0 when deselected)
//   data_in           : transmit word, loaded when ss falls
//   data_out          : last complete received word
//   done              : one-cycle pulse when a full word was received
// Build option: define SPI_LSB_FIRST_EN for LSB-first shifting.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done
);
    localparam int               CNT_W    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic              r_sclk_q;
    logic              r_ss_q;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_miso;
    logic [DATA_W-1:0] r_data_out;
    logic              r_done;

    logic              w_ss_fall;
    logic              w_ss_rise;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_tx_first;
    logic              w_tx_next;
    logic [DATA_W-1:0] w_tx_shifted;
    logic [DATA_W-1:0] w_rx_shifted;

    assign w_ss_fall   =  r_ss_q   & ~ss;
    assign w_ss_rise   = ~r_ss_q   &  ss;
    assign w_sclk_rise = ~r_sclk_q &  sclk;
    assign w_sclk_fall =  r_sclk_q & ~sclk;

`ifdef SPI_LSB_FIRST_EN
    assign w_tx_first   = data_in[0];
    assign w_tx_next    = r_tx[1];
    assign w_tx_shifted = r_tx >> 1;
    assign w_rx_shifted = {mosi, r_rx[DATA_W-1:1]};
`else
    assign w_tx_first   = data_in[DATA_W-1];
    assign w_tx_next    = r_tx[DATA_W-2];
    assign w_tx_shifted = r_tx << 1;
    assign w_rx_shifted = {r_rx[DATA_W-2:0], mosi};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_q   <= 1'b0;
            r_ss_q     <= 1'b1;   // matches idle ss so reset never looks like an ss edge
            r_tx       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_miso     <= 1'b0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_sclk_q <= sclk;
            r_ss_q   <= ss;
            r_done   <= 1'b0;
            if (w_ss_fall) begin
                r_tx   <= data_in;
                r_miso <= w_tx_first;
                r_cnt  <= '0;
            end else if (w_ss_rise) begin
                // A short frame (aborted master) is dropped silently.
                if (r_cnt == CNT_FULL) begin
                    r_data_out <= r_rx;
                    r_done     <= 1'b1;
                end
                r_miso <= 1'b0;
            end else if (!ss) begin
                if (w_sclk_rise) begin
                    r_rx  <= w_rx_shifted;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_sclk_fall) begin
                    r_tx   <= w_tx_shifted;
                    r_miso <= w_tx_next;
                end
            end
        end
    end

    assign miso     = r_miso;
    assign data_out = r_data_out;
    assign done     = r_done;

endmodule

// File: rtl/spi_master_slave.sv
// SPI mode-0 master plus an internally wired slave, one full-duplex
// DATA_W-bit exchange per accepted start edge. Bus pins are exported.
// Ports:
//   clk, reset              : system clock, synchronous active-high reset
//   start                   : transfer request, rising edge accepted in IDLE
//   m_data_in / s_data_in   : master / slave transmit words
//   m_data_out, m_done      : master received word and completion pulse
//   s_data_out, s_done      : slave received word and completion pulse
//   sclk, mosi, miso, ss    : observed SPI bus
// Build option: define SPI_LSB_FIRST_EN for LSB-first shifting.
//
// state | meaning
// IDLE  | bus idle, waiting for a start edge
// SETUP | ss low, first bit on mosi, sclk low for CLK_DIV cycles
// SHIFT | 2*DATA_W half-periods, sclk toggling at each boundary
// DONE  | one cycle: ss high, m_done asserted
module spi_master_slave
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] m_data_in,
    input  logic [DATA_W-1:0] s_data_in,
    output logic [DATA_W-1:0] m_data_out,
    output logic              m_done,
    output logic [DATA_W-1:0] s_data_out,
    output logic              s_done,
    output logic              sclk,
    output logic              mosi,
    output logic              miso,
    output logic              ss
);
    localparam int                DIV_W      = $clog2(CLK_DIV);
    localparam int                HALF_W     = cnt_w(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * DATA_W - 1);

    master_state_t     r_state;
    master_state_t     w_next_state;
    logic              r_start_d;
    logic [DIV_W-1:0]  r_div;
    logic [HALF_W-1:0] r_half;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_data_out;
    logic              r_sclk;
    logic              r_ss;
    logic              r_mosi;

    logic              w_start_edge;
    logic              w_tick;
    logic              w_last_half;
    logic              w_miso;
    logic              w_tx_first;
    logic              w_tx_next;
    logic [DATA_W-1:0] w_tx_shifted;
    logic [DATA_W-1:0] w_rx_shifted;

    assign w_start_edge = start & ~r_start_d;
    assign w_tick       = (r_div == '0);
    assign w_last_half  = (r_half == HALF_LAST);

`ifdef SPI_LSB_FIRST_EN
    assign w_tx_first   = m_data_in[0];
    assign w_tx_next    = r_tx[1];
    assign w_tx_shifted = r_tx >> 1;
    assign w_rx_shifted = {w_miso, r_rx[DATA_W-1:1]};
`else
    assign w_tx_first   = m_data_in[DATA_W-1];
    assign w_tx_next    = r_tx[DATA_W-2];
    assign w_tx_shifted = r_tx << 1;
    assign w_rx_shifted = {r_rx[DATA_W-2:0], w_miso};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_start_edge)          w_next_state = SETUP;
            SETUP:   if (w_tick)                w_next_state = SHIFT;
            SHIFT:   if (w_tick && w_last_half) w_next_state = DONE;
            DONE:                               w_next_state = IDLE;
            default:                            w_next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m_done = (r_state == DONE);
    end

    // Master datapath: divider, half-period counter, shift registers, bus pins.
    // ss/mosi/m_data_out are updated on the edge entering DONE so they are
    // already valid while m_done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_d  <= 1'b0;
            r_div      <= '0;
            r_half     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_sclk     <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_start_d <= start;
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_tx   <= m_data_in;
                        r_mosi <= w_tx_first;
                        r_ss   <= 1'b0;
                        r_div  <= DIV_RELOAD;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_div  <= DIV_RELOAD;
                        r_half <= '0;
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_div  <= DIV_RELOAD;
                        r_half <= r_half + HALF_W'(1);
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_rx <= w_rx_shifted;
                        end else if (!w_last_half) begin
                            r_tx   <= w_tx_shifted;
                            r_mosi <= w_tx_next;
                        end
                        if (w_last_half) begin
                            r_ss       <= 1'b1;
                            r_mosi     <= 1'b0;
                            r_data_out <= r_rx;
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    spi_slave_core #(
        .DATA_W (DATA_W)
    ) u_slave (
        .clk      (clk),
        .reset    (reset),
        .sclk     (r_sclk),
        .ss       (r_ss),
        .mosi     (r_mosi),
        .miso     (w_miso),
        .data_in  (s_data_in),
        .data_out (s_data_out),
        .done     (s_done)
    );

    assign m_data_out = r_data_out;
    assign sclk       = r_sclk;
    assign ss         = r_ss;
    assign mosi       = r_mosi;
    assign miso       = w_miso;

endmodule

// File: tb/tb_spi_master_slave.sv
// Bench for spi_master_slave: instance 0 uses CLK_DIV=2, instance 1 CLK_DIV=4.
// Expected words and completion cycles are queued when a start is issued
// and checked by per-instance monitors whenever a done pulse appears.
module tb_spi_master_slave;
    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] data;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset      [2];
    logic       start      [2];
    logic [7:0] m_data_in  [2];
    logic [7:0] s_data_in  [2];
    logic [7:0] m_data_out [2];
    logic [7:0] s_data_out [2];
    logic       m_done     [2];
    logic       s_done     [2];
    logic       sclk       [2];
    logic       mosi       [2];
    logic       miso       [2];
    logic       ss         [2];

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_m [2][$];
    exp_t q_s [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        int div;
        div = (d == 0) ? 2 : 4;
        return div * (1 + 2 * DW) + 1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_master_slave #(
            .DATA_W  (DW),
            .CLK_DIV ((g == 0) ? 2 : 4)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .start      (start[g]),
            .m_data_in  (m_data_in[g]),
            .s_data_in  (s_data_in[g]),
            .m_data_out (m_data_out[g]),
            .m_done     (m_done[g]),
            .s_data_out (s_data_out[g]),
            .s_done     (s_done[g]),
            .sclk       (sclk[g]),
            .mosi       (mosi[g]),
            .miso       (miso[g]),
            .ss         (ss[g])
        );

        always @(negedge clk) begin : mon
            exp_t e;
            if (m_done[g] === 1'b1) begin
                if (q_m[g].size() == 0) begin
                    chk("m_done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_m[g].pop_front();
                    chk("m_data_out", 32'(m_data_out[g]), 32'(e.data));
                    chk("m_done_cycle", cyc, e.t);
                end
            end
            if (s_done[g] === 1'b1) begin
                if (q_s[g].size() == 0) begin
                    chk("s_done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_s[g].pop_front();
                    chk("s_data_out", 32'(s_data_out[g]), 32'(e.data));
                    chk("s_done_cycle", cyc, e.t);
                end
            end
        end
    end

    // One transfer: full duplex swap, done at start cycle + latency.
    task automatic do_xfer(input int d, input logic [7:0] m_in, input logic [7:0] s_in,
                           input int hold, input bit chg);
        int   c;
        int   n;
        int   rises;
        int   ss_bad;
        logic prev_sclk;
        n = (hold > lat(d)) ? hold : lat(d) + 1;
        @(negedge clk);
        m_data_in[d] = m_in;
        s_data_in[d] = s_in;
        start[d]     = 1'b1;
        c            = cyc;
        q_m[d].push_back('{data: s_in, t: c + lat(d)});
        q_s[d].push_back('{data: m_in, t: c + lat(d) + 1});
        rises     = 0;
        ss_bad    = 0;
        prev_sclk = sclk[d];
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == hold) start[d] = 1'b0;
            if (chg && k == 3) begin
                m_data_in[d] = 8'($urandom);
                s_data_in[d] = 8'($urandom);
            end
            if (k <= lat(d)) begin
                if (sclk[d] && !prev_sclk) rises++;
                prev_sclk = sclk[d];
                if (k < lat(d) && ss[d] !== 1'b0) ss_bad++;
            end
            if (k == lat(d)) begin
                chk("ss_high_in_done", 32'(ss[d]), 32'd1);
                chk("sclk_low_in_done", 32'(sclk[d]), 32'd0);
            end
        end
        start[d] = 1'b0;
        chk("sclk_rises", rises, DW);
        chk("ss_low_during_xfer", ss_bad, 0);
        chk("ss_idle_after", 32'(ss[d]), 32'd1);
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_ss"},    32'(ss[d]),   32'd1);
        chk({tag, "_sclk"},  32'(sclk[d]), 32'd0);
        chk({tag, "_mosi"},  32'(mosi[d]), 32'd0);
        chk({tag, "_miso"},  32'(miso[d]), 32'd0);
        chk({tag, "_m_out"}, 32'(m_data_out[d]), 32'd0);
        chk({tag, "_s_out"}, 32'(s_data_out[d]), 32'd0);
        chk({tag, "_m_done"}, 32'(m_done[d]), 32'd0);
        chk({tag, "_s_done"}, 32'(s_done[d]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1'b1;
            start[i]     = 1'b0;
            m_data_in[i] = '0;
            s_data_in[i] = '0;
        end
        repeat (2) @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");

        // Basic exchange, start held 20 cycles.
        do_xfer(0, 8'hA5, 8'h3C, 20, 1'b0);

        // Back-to-back, start dropped when m_done is seen.
        do_xfer(0, 8'hFF, 8'h00, lat(0), 1'b0);
        do_xfer(0, 8'h00, 8'hFF, lat(0), 1'b0);

        // start held for 100 cycles: exactly one transfer.
        do_xfer(0, 8'h96, 8'h69, 100, 1'b0);

        // Inputs changed mid-transfer.
        do_xfer(0, 8'h5A, 8'hC3, lat(0) + 1, 1'b1);

        // Randomised transfers.
        for (int i = 0; i < 12; i++) begin
            do_xfer(0, 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)));
        end

        // Reset 15 cycles into a transfer: abort, no done pulses.
        @(negedge clk);
        m_data_in[0] = 8'h77;
        s_data_in[0] = 8'hEE;
        start[0]     = 1'b1;
        repeat (15) @(negedge clk);
        start[0] = 1'b0;
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        chk_idle(0, "abort");
        repeat (60) @(negedge clk);

        // Recovery after the abort.
        do_xfer(0, 8'h12, 8'h34, 10, 1'b0);

        // CLK_DIV=4 instance.
        do_xfer(1, 8'h81, 8'h7E, 20, 1'b0);

        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("m_done_missing", q_m[d].size(), 0);
            chk("s_done_missing", q_s[d].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
